// File: rtl/sa_cache_controller.sv
// sa_cache_controller
//   Write-back, write-allocate cache controller with LINE_WORDS-word lines and
//   1- or 2-way set associativity. It sits between the core load/store port and
//   the on-chip RAM controller. A miss first writes back a dirty victim line
//   word by word, then refills the line word by word, then re-runs the lookup.
//   That final lookup always hits and completes the request.
//
//   Optional feature macro: CACHE_STATS_EN adds the hit_count/miss_count ports.
//   The counters saturate and count only the first lookup of each request.
//
// Ports
//   iCLK, iRST            clock, asynchronous active-high reset
//   cpu2cache_*           CPU request: byte address, rw (1=write), valid strobe, write data
//   cache2cpu_data_out    read data, held until the next completed read
//   cache2cpu_ready       controller idle; a request is accepted when valid && ready
//   cache2mem_*           word-aligned memory address, write-back data, MemWrite/MemRead
//   mem2cache_data_in     refill data
//   mem2cache_ready       one-cycle acknowledge for the current memory word
//   hit_count/miss_count  statistics (CACHE_STATS_EN only)

// Per-way tag comparator, instantiated once per way.
module sa_cache_tag_cmp #(
  parameter int TAG_W = 24
) (
  input  logic             valid,
  input  logic [TAG_W-1:0] tag,
  input  logic [TAG_W-1:0] req_tag,
  output logic             hit
);
  assign hit = valid && (tag == req_tag);
endmodule

module sa_cache_controller #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 4,
  parameter int LINE_W = 2,
  parameter int WAYS   = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] cpu2cache_addr,
  input  logic              cpu2cache_rw,
  input  logic              cpu2cache_valid,
  input  logic [DATA_W-1:0] cpu2cache_data_in,
  output logic [DATA_W-1:0] cache2cpu_data_out,
  output logic              cache2cpu_ready,
  output logic [ADDR_W-1:0] cache2mem_addr,
  output logic [DATA_W-1:0] cache2mem_data,
  output logic              cache2mem_MemWrite,
  output logic              cache2mem_MemRead,
  input  logic [DATA_W-1:0] mem2cache_data_in,
  input  logic              mem2cache_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W      = ADDR_W - IDX_W - LINE_W - 2;
  localparam int SETS       = 1 << IDX_W;
  localparam int LINE_WORDS = 1 << LINE_W;
  localparam logic [LINE_W-1:0] K_LAST = LINE_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WRITEBACK, S_ALLOCATE} state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] word;
    logic              rw;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t                    state_q;
  req_t                      req_q;
  logic [WAYS-1:0][SETS-1:0] valid_q, dirty_q;
  logic [SETS-1:0]           lru_q;      // way to evict next in each set
  logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
  logic [DATA_W-1:0]         data_q [WAYS][SETS][LINE_WORDS];
  logic                      victim_q;   // way being written back / refilled
  logic [LINE_W-1:0]         k_q, k_nxt;

  // The low address bits select a byte inside the word and play no part here.
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^cpu2cache_addr[1:0];

  assign k_nxt = k_q + LINE_W'(1);

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0]  t,
                                                  input logic [IDX_W-1:0]  i,
                                                  input logic [LINE_W-1:0] k);
    return {t, i, k, 2'b00};
  endfunction

  // ---------------------------------------------------------------- lookup
  logic [WAYS-1:0] hit_vec;
  logic [1:0]      hit2, set_vld;
  logic            hit_any, hit_way, vict_way, vict_dirty;

  genvar w;
  generate
    for (w = 0; w < WAYS; w++) begin : g_way
      sa_cache_tag_cmp #(.TAG_W(TAG_W)) u_cmp (
        .valid   (valid_q[w][req_q.idx]),
        .tag     (tag_q[w][req_q.idx]),
        .req_tag (req_q.tag),
        .hit     (hit_vec[w])
      );
    end
    // Way slots that do not exist read as valid, so they are never picked as
    // an empty victim.
    for (w = 0; w < 2; w++) begin : g_vld
      if (w < WAYS) begin : g_real
        assign set_vld[w] = valid_q[w][req_q.idx];
      end else begin : g_pad
        assign set_vld[w] = 1'b1;
      end
    end
  endgenerate

  assign hit2    = 2'(hit_vec);
  assign hit_any = |hit_vec;
  assign hit_way = hit2[1];

  // Victim: first empty way (way 0 first), otherwise the LRU way.
  always_comb begin
    vict_way = 1'b0;
    if (!set_vld[0])     vict_way = 1'b0;
    else if (!set_vld[1]) vict_way = 1'b1;
    else if (WAYS == 2)  vict_way = lru_q[req_q.idx];
  end

  assign vict_dirty = valid_q[vict_way][req_q.idx] && dirty_q[vict_way][req_q.idx];

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q            <= S_IDLE;
      req_q              <= '0;
      victim_q           <= 1'b0;
      k_q                <= '0;
      valid_q            <= '0;
      dirty_q            <= '0;
      lru_q              <= '0;
      cache2cpu_ready    <= 1'b1;
      cache2cpu_data_out <= '0;
      cache2mem_addr     <= '0;
      cache2mem_data     <= '0;
      cache2mem_MemWrite <= 1'b0;
      cache2mem_MemRead  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cpu2cache_valid) begin
            req_q.tag       <= cpu2cache_addr[ADDR_W-1 -: TAG_W];
            req_q.idx       <= cpu2cache_addr[2+LINE_W +: IDX_W];
            req_q.word      <= cpu2cache_addr[2 +: LINE_W];
            req_q.rw        <= cpu2cache_rw;
            req_q.wdata     <= cpu2cache_data_in;
            cache2cpu_ready <= 1'b0;
            state_q         <= S_COMPARE;
          end
        end

        S_COMPARE: begin
          if (hit_any) begin
            if (!req_q.rw) cache2cpu_data_out <= data_q[hit_way][req_q.idx][req_q.word];
            else           dirty_q[hit_way][req_q.idx] <= 1'b1;
            if (WAYS == 2) lru_q[req_q.idx] <= ~hit_way;
            cache2cpu_ready <= 1'b1;
            state_q         <= S_IDLE;
          end else begin
            victim_q <= vict_way;
            k_q      <= '0;
            if (vict_dirty) begin
              cache2mem_addr     <= line_addr(tag_q[vict_way][req_q.idx], req_q.idx, '0);
              cache2mem_data     <= data_q[vict_way][req_q.idx][0];
              cache2mem_MemWrite <= 1'b1;
              state_q            <= S_WRITEBACK;
            end else begin
              // The line is overwritten from here on; keep it invalid until full.
              valid_q[vict_way][req_q.idx] <= 1'b0;
              cache2mem_addr               <= line_addr(req_q.tag, req_q.idx, '0);
              cache2mem_MemRead            <= 1'b1;
              state_q                      <= S_ALLOCATE;
            end
          end
        end

        S_WRITEBACK: begin
          if (mem2cache_ready) begin
            if (k_q == K_LAST) begin
              dirty_q[victim_q][req_q.idx] <= 1'b0;
              valid_q[victim_q][req_q.idx] <= 1'b0;
              k_q                          <= '0;
              cache2mem_MemWrite           <= 1'b0;
              cache2mem_MemRead            <= 1'b1;
              cache2mem_addr               <= line_addr(req_q.tag, req_q.idx, '0);
              state_q                      <= S_ALLOCATE;
            end else begin
              k_q            <= k_nxt;
              cache2mem_addr <= line_addr(tag_q[victim_q][req_q.idx], req_q.idx, k_nxt);
              cache2mem_data <= data_q[victim_q][req_q.idx][k_nxt];
            end
          end
        end

        S_ALLOCATE: begin
          if (mem2cache_ready) begin
            if (k_q == K_LAST) begin
              valid_q[victim_q][req_q.idx] <= 1'b1;
              dirty_q[victim_q][req_q.idx] <= 1'b0;
              k_q                          <= '0;
              cache2mem_MemRead            <= 1'b0;
              state_q                      <= S_COMPARE;
            end else begin
              k_q            <= k_nxt;
              cache2mem_addr <= line_addr(req_q.tag, req_q.idx, k_nxt);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge iCLK) begin
    if (state_q == S_COMPARE && hit_any && req_q.rw)
      data_q[hit_way][req_q.idx][req_q.word] <= req_q.wdata;
    if (state_q == S_ALLOCATE && mem2cache_ready) begin
      data_q[victim_q][req_q.idx][k_q] <= mem2cache_data_in;
      if (k_q == K_LAST) tag_q[victim_q][req_q.idx] <= req_q.tag;
    end
  end

`ifdef CACHE_STATS_EN
  // first_cmp_q marks the lookup right after acceptance; the lookup that
  // follows a refill is not counted again.
  logic first_cmp_q;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      hit_count   <= '0;
      miss_count  <= '0;
      first_cmp_q <= 1'b0;
    end else if (state_q == S_IDLE && cpu2cache_valid) begin
      first_cmp_q <= 1'b1;
    end else if (state_q == S_COMPARE) begin
      first_cmp_q <= 1'b0;
      if (first_cmp_q) begin
        if (hit_any) begin
          if (hit_count != '1) hit_count <= hit_count + 32'd1;
        end else begin
          if (miss_count != '1) miss_count <= miss_count + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_sa_cache_controller.sv
// Scoreboard bench for sa_cache_controller (default parameters: 16 sets,
// 4-word lines, 2 ways). Stimulus pushes expected memory-bus words and CPU
// read results into queues; two monitors pop and compare them when the DUT
// presents an acknowledged memory word or completes a request.
module tb_sa_cache_controller;

  logic        iCLK;
  logic        iRST;
  logic [31:0] c_addr, c_wdata, c_rdata;
  logic        c_rw, c_valid, c_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_we, m_re, m_rdy;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  sa_cache_controller dut (
    .iCLK               (iCLK),
    .iRST               (iRST),
    .cpu2cache_addr     (c_addr),
    .cpu2cache_rw       (c_rw),
    .cpu2cache_valid    (c_valid),
    .cpu2cache_data_in  (c_wdata),
    .cache2cpu_data_out (c_rdata),
    .cache2cpu_ready    (c_ready),
    .cache2mem_addr     (m_addr),
    .cache2mem_data     (m_wdata),
    .cache2mem_MemWrite (m_we),
    .cache2mem_MemRead  (m_re),
    .mem2cache_data_in  (m_rdata),
    .mem2cache_ready    (m_rdy)
`ifdef CACHE_STATS_EN
    ,
    .hit_count          (hit_count),
    .miss_count         (miss_count)
`endif
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } mexp_t;
  typedef struct { logic rd; logic [31:0] data; } cexp_t;
  mexp_t mq[$];
  cexp_t cq[$];

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_len  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_rd_line(input logic [31:0] base);
    for (int k = 0; k < 4; k++) mq.push_back('{wr: 1'b0, addr: base + 32'(4*k), data: 32'h0});
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    mq.push_back('{wr: 1'b1, addr: a, data: d});
  endtask

  task automatic push_cpu(input logic rd, input logic [31:0] d);
    cq.push_back('{rd: rd, data: d});
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!c_ready && n < 500) begin
      @(posedge iCLK); #1;
      n++;
    end
    if (!c_ready) chk("idle_timeout", {31'b0, c_ready}, 32'd1);
  endtask

  task automatic cpu_req(input logic rw, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    c_valid = 1'b1; c_rw = rw; c_addr = a; c_wdata = d;
    @(posedge iCLK); #1;
    c_valid = 1'b0;
  endtask

  // Memory model: acknowledges every cycle a request is up, except for
  // stall_len cycles the first time stall_addr is requested.
  initial begin
    logic [31:0] mem [0:1023];
    int held = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
    for (int k = 0; k < 4; k++) begin
      mem[16+k]  = 32'h0400 + 32'(k);
      mem[32+k]  = 32'h0800 + 32'(k);
      mem[64+k]  = 32'h1000 + 32'(k);
      mem[128+k] = 32'h2000 + 32'(k);
    end
    m_rdy = 1'b0; m_rdata = '0;
    forever begin
      @(negedge iCLK);
      m_rdy = 1'b0;
      if (!iRST && (m_re || m_we)) begin
        if (m_addr == stall_addr && held < stall_len) begin
          held++;
        end else begin
          m_rdy = 1'b1;
          if (m_we) mem[m_addr[11:2]] = m_wdata;
          else      m_rdata = mem[m_addr[11:2]];
        end
      end
    end
  end

  // Memory-bus monitor.
  initial begin
    mexp_t e;
    forever begin
      @(negedge iCLK); #1;
      if (!iRST && m_rdy && (m_re || m_we)) begin
        chk("mem_rd_wr_exclusive", {31'b0, m_re && m_we}, 32'd0);
        if (mq.size() == 0) begin
          chk("mem_unexpected_addr", m_addr, 32'hFFFF_FFFF);
        end else begin
          e = mq.pop_front();
          chk("mem_dir_is_write", {31'b0, m_we}, {31'b0, e.wr});
          chk("mem_addr", m_addr, e.addr);
          if (e.wr) chk("mem_wdata", m_wdata, e.data);
        end
      end
    end
  end

  // CPU completion monitor: a rising ready ends a request.
  initial begin
    cexp_t e;
    logic  prev = 1'b1;
    forever begin
      @(negedge iCLK); #1;
      if (iRST) begin
        prev = 1'b1;
      end else begin
        if (!prev && c_ready) begin
          if (cq.size() == 0) begin
            chk("cpu_unexpected_done", c_rdata, 32'hFFFF_FFFF);
          end else begin
            e = cq.pop_front();
            if (e.rd) chk("cpu_rdata", c_rdata, e.data);
          end
        end
        prev = c_ready;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    c_valid = 1'b0; c_rw = 1'b0; c_addr = '0; c_wdata = '0;
    iRST = 1'b1;
    #1;
    chk("rst_ready",    {31'b0, c_ready}, 32'd1);
    chk("rst_data_out", c_rdata, 32'd0);
    chk("rst_mem_addr", m_addr, 32'd0);
    chk("rst_mem_data", m_wdata, 32'd0);
    chk("rst_memread",  {31'b0, m_re}, 32'd0);
    chk("rst_memwrite", {31'b0, m_we}, 32'd0);
`ifdef CACHE_STATS_EN
    chk("rst_hit_count",  hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
`endif
    repeat (2) @(posedge iCLK);
    #2 iRST = 1'b0;

    // Cold read miss: refill 0x000-0x00C, word 1 returned.
    push_rd_line(32'h000);
    push_cpu(1'b1, 32'd22);
    cpu_req(1'b0, 32'h004, '0);
    wait_idle();

    // Write hit: two-cycle completion, no memory traffic; read back.
    push_cpu(1'b0, '0);
    cpu_req(1'b1, 32'h008, 32'd5);
    chk("hit_lat_busy", {31'b0, c_ready}, 32'd0);
    @(posedge iCLK); #1;
    chk("hit_lat_done", {31'b0, c_ready}, 32'd1);
    push_cpu(1'b1, 32'd5);
    cpu_req(1'b0, 32'h008, '0);
    wait_idle();

    // Fill way 1, then evict dirty way 0 (LRU) on the third tag in set 0.
    push_rd_line(32'h100);
    push_cpu(1'b1, 32'h1001);
    cpu_req(1'b0, 32'h104, '0);
    wait_idle();
    push_wr(32'h000, 32'd11);
    push_wr(32'h004, 32'd22);
    push_wr(32'h008, 32'd5);
    push_wr(32'h00C, 32'd44);
    push_rd_line(32'h200);
    push_cpu(1'b1, 32'h2001);
    cpu_req(1'b0, 32'h204, '0);
    wait_idle();
    // Way 1 must have survived the eviction.
    push_cpu(1'b1, 32'h1003);
    cpu_req(1'b0, 32'h10C, '0);
    wait_idle();

    // Memory stalls 5 cycles on the third refill word.
    stall_addr = 32'h048;
    stall_len  = 5;
    push_rd_line(32'h040);
    push_cpu(1'b1, 32'h0401);
    cpu_req(1'b0, 32'h044, '0);
    n = 0;
    while (!(m_addr == 32'h048 && m_re) && n < 100) begin
      @(negedge iCLK); #1;
      n++;
    end
    chk("stall_reached_addr", m_addr, 32'h048);
    for (int i = 0; i < 5; i++) begin
      chk("stall_addr_stable", m_addr, 32'h048);
      chk("stall_memread_held", {31'b0, m_re}, 32'd1);
      chk("stall_ready_low", {31'b0, c_ready}, 32'd0);
      @(negedge iCLK); #1;
    end
    wait_idle();

    // Reset while the second refill word is outstanding.
    push_wr(32'hFFFF_FFFF, 32'h0);
    void'(mq.pop_back());
    mq.push_back('{wr: 1'b0, addr: 32'h080, data: 32'h0});
    cpu_req(1'b0, 32'h084, '0);
    n = 0;
    while (!(m_rdy && m_addr == 32'h080) && n < 100) begin
      @(negedge iCLK); #1;
      n++;
    end
    chk("rst_burst_first_ack", m_addr, 32'h080);
    @(posedge iCLK); #2;
    chk("rst_burst_2nd_addr", m_addr, 32'h084);
    chk("rst_burst_2nd_rd", {31'b0, m_re}, 32'd1);
    iRST = 1'b1;
    #1;
    chk("rst_burst_memread", {31'b0, m_re}, 32'd0);
    chk("rst_burst_memwrite", {31'b0, m_we}, 32'd0);
    chk("rst_burst_ready", {31'b0, c_ready}, 32'd1);
    chk("rst_burst_addr", m_addr, 32'd0);
    @(posedge iCLK); #2;
    iRST = 1'b0;
    push_rd_line(32'h080);
    push_cpu(1'b1, 32'h0801);
    cpu_req(1'b0, 32'h084, '0);
    wait_idle();

    // Statistics: one miss then one hit from a clean reset.
    @(posedge iCLK); #2;
    iRST = 1'b1;
    @(posedge iCLK); #2;
    iRST = 1'b0;
    push_rd_line(32'h000);
    push_cpu(1'b1, 32'd22);
    cpu_req(1'b0, 32'h004, '0);
    wait_idle();
    push_cpu(1'b1, 32'd22);
    cpu_req(1'b0, 32'h004, '0);
    wait_idle();
`ifdef CACHE_STATS_EN
    chk("stats_miss_count", miss_count, 32'd1);
    chk("stats_hit_count",  hit_count, 32'd1);
`endif
    // Written-back word came back from memory on the refill.
    push_cpu(1'b1, 32'd5);
    cpu_req(1'b0, 32'h008, '0);
    wait_idle();

    repeat (3) @(negedge iCLK);
    n = 0;
    while ((mq.size() != 0 || cq.size() != 0) && n < 50) begin
      @(negedge iCLK); #1;
      n++;
    end
    chk("mem_queue_drained", 32'(mq.size()), 32'd0);
    chk("cpu_queue_drained", 32'(cq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
